// File: rtl/exc_pipe_tracker.sv
// exc_pipe_tracker
//   Carries exception-tracking state for each instruction alongside the main
//   pipeline (D -> E -> M). The state is the PC, the delay-slot bit and the
//   exception flags, and at M also the faulting address. The M-stage view is
//   handed to CP0 and used to suppress memory access and writeback.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stallF/D/E/M                  hold the corresponding stage register
//   flushD/E/M                    hazard flush, stage becomes a bubble
//   flush_exception               exception/eret at M, flushes D, E and M
//   pcF                           fetch PC
//   riD, syscallD, breakD, eretD  decode-stage exception sources
//   is_branchD                    D instruction is a branch/jump
//   overflowE, trapE              execute-stage exception sources
//   mem_readE, mem_writeE         load/store in E
//   mem_sizeE                     0 byte, 1 half, 2/3 word
//   aluoutE                       effective address / ALU result
//   pcM, in_dsM, validM           M-stage instruction info
//   exc_flagsM                    {addrErrSw, addrErrLw, trap, ovf, eret,
//                                  break, syscall, ri, pcError}
//   badaddrM                      BadVAddr candidate
//   kill_memM                     suppress memory access and writeback
module exc_pipe_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        stallE,
  input  logic        stallM,
  input  logic        flushD,
  input  logic        flushE,
  input  logic        flushM,
  input  logic        flush_exception,
  input  logic [31:0] pcF,
  input  logic        riD,
  input  logic        syscallD,
  input  logic        breakD,
  input  logic        eretD,
  input  logic        is_branchD,
  input  logic        overflowE,
  input  logic        trapE,
  input  logic        mem_readE,
  input  logic        mem_writeE,
  input  logic [1:0]  mem_sizeE,
  input  logic [31:0] aluoutE,
  output logic [31:0] pcM,
  output logic        in_dsM,
  output logic        validM,
  output logic [8:0]  exc_flagsM,
  output logic [31:0] badaddrM,
  output logic        kill_memM
);

  // D and E only carry the flag bits that can be set by then, and no
  // badaddr: upper flags are always zero before M, and badaddr is formed
  // at the E->M transfer.
  logic        r_d_valid;
  logic [31:0] r_d_pc;
  logic        r_d_ds;
  logic        r_d_flags;

  logic        r_e_valid;
  logic [31:0] r_e_pc;
  logic        r_e_ds;
  logic [4:0]  r_e_flags;

  logic        r_m_valid;
  logic [31:0] r_m_pc;
  logic        r_m_ds;
  logic [8:0]  r_m_flags;
  logic [31:0] r_m_bad;

  logic        w_pc_err;
  logic [3:0]  w_d_new;
  logic        w_mis;
  logic        w_lw_err;
  logic        w_sw_err;
  logic [3:0]  w_e_new;

  assign w_pc_err = |pcF[1:0];
  assign w_d_new  = r_d_valid ? {eretD, breakD, syscallD, riD} : '0;

  always_comb begin
    w_mis = 1'b0;
    case (mem_sizeE)
      2'd0:    w_mis = 1'b0;
      2'd1:    w_mis = aluoutE[0];
      default: w_mis = |aluoutE[1:0];
    endcase
  end

  assign w_lw_err = mem_readE & w_mis;
  assign w_sw_err = mem_writeE & w_mis & ~mem_readE;

  // Earlier-stage exceptions take precedence, so E detection is masked.
  assign w_e_new = (r_e_valid && (r_e_flags == 5'd0))
                   ? {w_sw_err, w_lw_err, trapE, overflowE} : '0;

  always_ff @(posedge clk) begin
    if (rst || flushD || flush_exception) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= '0;
      r_d_ds    <= 1'b0;
      r_d_flags <= 1'b0;
    end else if (stallD) begin
      r_d_valid <= r_d_valid;
    end else if (stallF) begin
      r_d_valid <= 1'b0;
      r_d_pc    <= '0;
      r_d_ds    <= 1'b0;
      r_d_flags <= 1'b0;
    end else begin
      r_d_valid <= 1'b1;
      r_d_pc    <= pcF;
      // The incoming instruction is a delay slot if the one leaving D branches.
      r_d_ds    <= r_d_valid & is_branchD;
      r_d_flags <= w_pc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushE || flush_exception) begin
      r_e_valid <= 1'b0;
      r_e_pc    <= '0;
      r_e_ds    <= 1'b0;
      r_e_flags <= '0;
    end else if (stallE) begin
      r_e_valid <= r_e_valid;
    end else if (stallD) begin
      r_e_valid <= 1'b0;
      r_e_pc    <= '0;
      r_e_ds    <= 1'b0;
      r_e_flags <= '0;
    end else begin
      r_e_valid <= r_d_valid;
      r_e_pc    <= r_d_pc;
      r_e_ds    <= r_d_ds;
      r_e_flags <= {w_d_new, r_d_flags & r_d_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushM || flush_exception) begin
      r_m_valid <= 1'b0;
      r_m_pc    <= '0;
      r_m_ds    <= 1'b0;
      r_m_flags <= '0;
      r_m_bad   <= '0;
    end else if (stallM) begin
      r_m_valid <= r_m_valid;
    end else if (stallE) begin
      r_m_valid <= 1'b0;
      r_m_pc    <= '0;
      r_m_ds    <= 1'b0;
      r_m_flags <= '0;
      r_m_bad   <= '0;
    end else begin
      r_m_valid <= r_e_valid;
      r_m_pc    <= r_e_pc;
      r_m_ds    <= r_e_ds;
      r_m_flags <= {w_e_new, r_e_flags};
      r_m_bad   <= r_e_flags[0] ? r_e_pc : aluoutE;
    end
  end

  assign pcM        = r_m_pc;
  assign in_dsM     = r_m_ds;
  assign validM     = r_m_valid;
  assign exc_flagsM = r_m_flags;
  assign badaddrM   = r_m_bad;
  assign kill_memM  = r_m_valid & (|r_m_flags);

endmodule

// File: tb/tb_exc_pipe_tracker.sv
// tb_exc_pipe_tracker
//   Streams a table of instructions through the tracker with each stage's
//   inputs presented in the cycle the instruction occupies that stage, and
//   compares M-stage outputs against a queue of expected results. Directed
//   sequences then cover stalls, flushes and mid-stream reset.
module tb_exc_pipe_tracker;

  logic        clk;
  logic        rst;
  logic        stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushM, flush_exception;
  logic [31:0] pcF;
  logic        riD, syscallD, breakD, eretD, is_branchD;
  logic        overflowE, trapE, mem_readE, mem_writeE;
  logic [1:0]  mem_sizeE;
  logic [31:0] aluoutE;
  logic [31:0] pcM;
  logic        in_dsM, validM;
  logic [8:0]  exc_flagsM;
  logic [31:0] badaddrM;
  logic        kill_memM;

  exc_pipe_tracker dut (
    .clk(clk), .rst(rst),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flush_exception(flush_exception),
    .pcF(pcF),
    .riD(riD), .syscallD(syscallD), .breakD(breakD), .eretD(eretD),
    .is_branchD(is_branchD),
    .overflowE(overflowE), .trapE(trapE),
    .mem_readE(mem_readE), .mem_writeE(mem_writeE), .mem_sizeE(mem_sizeE),
    .aluoutE(aluoutE),
    .pcM(pcM), .in_dsM(in_dsM), .validM(validM), .exc_flagsM(exc_flagsM),
    .badaddrM(badaddrM), .kill_memM(kill_memM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ri, sys, brk, eret, br;
    logic        ovf, trap, rd, wr;
    logic [1:0]  size;
    logic [31:0] addr;
  } inst_t;

  typedef struct {
    logic [31:0] pc;
    logic        ds;
    logic [8:0]  flags;
    logic [31:0] bad;
    logic        kill;
  } exp_t;

  inst_t prog[$];
  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clr_in();
    stallF = 0; stallD = 0; stallE = 0; stallM = 0;
    flushD = 0; flushE = 0; flushM = 0; flush_exception = 0;
    pcF = '0; riD = 0; syscallD = 0; breakD = 0; eretD = 0; is_branchD = 0;
    overflowE = 0; trapE = 0; mem_readE = 0; mem_writeE = 0;
    mem_sizeE = '0; aluoutE = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    step();
    rst = 0;
  endtask

  // Independent per-instruction expectation derived from the exception rules.
  function automatic exp_t expect_of(input inst_t i, input logic prev_br);
    exp_t e;
    logic pcerr, mis, lw, sw;
    logic [4:0] fd;
    logic [3:0] fe;
    pcerr = (i.pc[1:0] != 2'b00);
    if (i.size == 2'd0)      mis = 1'b0;
    else if (i.size == 2'd1) mis = i.addr[0];
    else                     mis = (i.addr[1:0] != 2'b00);
    lw = i.rd & mis;
    sw = i.wr & mis & ~i.rd;
    fd = {i.eret, i.brk, i.sys, i.ri, pcerr};
    fe = (fd == 5'd0) ? {sw, lw, i.trap, i.ovf} : 4'd0;
    e.pc    = i.pc;
    e.ds    = prev_br;
    e.flags = {fe, fd};
    e.bad   = pcerr ? i.pc : i.addr;
    e.kill  = |e.flags;
    return e;
  endfunction

  initial begin
    int n;
    exp_t e;
    logic expv;

    // pc ri sys brk eret br ovf trap rd wr size addr
    prog.push_back('{32'hBFC00002, 0,0,0,0,0, 0,0,0,0, 2'd0, 32'h00000000});
    prog.push_back('{32'hBFC00004, 0,0,0,0,1, 0,0,1,0, 2'd2, 32'h80001002});
    prog.push_back('{32'h80000004, 0,0,0,0,0, 0,0,1,0, 2'd0, 32'h80001003});
    prog.push_back('{32'h80000008, 0,1,0,0,0, 1,0,0,0, 2'd0, 32'h00000010});
    prog.push_back('{32'h8000000C, 0,0,0,0,0, 0,0,0,1, 2'd1, 32'h80002001});
    prog.push_back('{32'h80000010, 0,0,0,0,0, 0,0,1,1, 2'd2, 32'h80002002});
    prog.push_back('{32'h80000014, 0,0,0,0,0, 0,1,0,0, 2'd0, 32'h00000000});
    prog.push_back('{32'h80000018, 0,0,0,1,0, 0,0,0,0, 2'd0, 32'h12345678});
    prog.push_back('{32'h8000001C, 1,0,0,0,0, 1,0,0,0, 2'd0, 32'h00000000});
    prog.push_back('{32'h80000020, 0,0,1,0,1, 0,0,0,0, 2'd0, 32'h00000000});
    prog.push_back('{32'hFFFFFFFC, 0,0,0,0,0, 0,0,1,0, 2'd3, 32'h80000004});
    prog.push_back('{32'h00000000, 0,0,0,0,0, 0,0,0,1, 2'd1, 32'h80000002});
    prog.push_back('{32'h00000003, 0,0,0,0,0, 1,0,1,0, 2'd2, 32'h80000001});
    n = prog.size();

    do_reset();
    check("rst_pcM", pcM, 32'h0);
    check("rst_in_dsM", {31'b0, in_dsM}, 32'h0);
    check("rst_validM", {31'b0, validM}, 32'h0);
    check("rst_flags", {23'b0, exc_flagsM}, 32'h0);
    check("rst_badaddr", badaddrM, 32'h0);
    check("rst_kill", {31'b0, kill_memM}, 32'h0);

    // Streaming: before edge c, F holds prog[c], D prog[c-1], E prog[c-2].
    for (int c = 0; c <= n + 1; c++) begin
      clr_in();
      if (c < n) begin
        pcF = prog[c].pc;
        sb.push_back(expect_of(prog[c], (c > 0) ? prog[c-1].br : 1'b0));
      end else begin
        stallF = 1;
      end
      if (c >= 1 && c <= n) begin
        riD = prog[c-1].ri; syscallD = prog[c-1].sys; breakD = prog[c-1].brk;
        eretD = prog[c-1].eret; is_branchD = prog[c-1].br;
      end
      if (c >= 2 && c <= n + 1) begin
        overflowE = prog[c-2].ovf; trapE = prog[c-2].trap;
        mem_readE = prog[c-2].rd; mem_writeE = prog[c-2].wr;
        mem_sizeE = prog[c-2].size; aluoutE = prog[c-2].addr;
      end
      step();
      expv = (c >= 2) && (c - 2 < n);
      check("stream_validM", {31'b0, validM}, {31'b0, expv});
      if (validM) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_pcM", pcM, e.pc);
          check("sb_in_dsM", {31'b0, in_dsM}, {31'b0, e.ds});
          check("sb_flags", {23'b0, exc_flagsM}, {23'b0, e.flags});
          check("sb_badaddr", badaddrM, e.bad);
          check("sb_kill", {31'b0, kill_memM}, {31'b0, e.kill});
        end
      end
    end
    check("sb_empty", sb.size(), 32'd0);

    // D stalled two cycles with E running: two bubbles, held D keeps pc/ds.
    do_reset();
    pcF = 32'h00000100; step();
    pcF = 32'h00000104; is_branchD = 1; step();
    stallD = 1; stallF = 1; is_branchD = 1; step();
    check("stl_A_valid", {31'b0, validM}, 32'd1);
    check("stl_A_pc", pcM, 32'h00000100);
    step();
    check("stl_bubble1", {31'b0, validM}, 32'd0);
    stallD = 0; is_branchD = 0; step();
    check("stl_bubble2", {31'b0, validM}, 32'd0);
    step();
    check("stl_B_valid", {31'b0, validM}, 32'd1);
    check("stl_B_pc", pcM, 32'h00000104);
    check("stl_B_ds", {31'b0, in_dsM}, 32'd1);

    // flush_exception beats stallM and also clears E.
    do_reset();
    pcF = 32'h00000202; step();
    pcF = 32'h00000300; step();
    stallF = 1; step();
    check("fx_pre_flags", {23'b0, exc_flagsM}, 32'h001);
    check("fx_pre_kill", {31'b0, kill_memM}, 32'd1);
    flush_exception = 1; stallM = 1; step();
    check("fx_validM", {31'b0, validM}, 32'd0);
    check("fx_flags", {23'b0, exc_flagsM}, 32'd0);
    check("fx_kill", {31'b0, kill_memM}, 32'd0);
    flush_exception = 0; stallM = 0; step();
    check("fx_E_cleared", {31'b0, validM}, 32'd0);

    // Hazard flushM, then reset mid-stream dominating stall/flush.
    do_reset();
    pcF = 32'h00000400; step();
    pcF = 32'h00000404; step();
    pcF = 32'h00000408; step();
    check("ms_valid", {31'b0, validM}, 32'd1);
    flushM = 1; pcF = 32'h0000040C; aluoutE = 32'h00000555; step();
    check("flushM_valid", {31'b0, validM}, 32'd0);
    flushM = 0;
    rst = 1; stallD = 1; stallM = 1; flushE = 1; step();
    check("mrst_pcM", pcM, 32'h0);
    check("mrst_valid", {31'b0, validM}, 32'd0);
    check("mrst_flags", {23'b0, exc_flagsM}, 32'd0);
    check("mrst_bad", badaddrM, 32'h0);
    check("mrst_ds", {31'b0, in_dsM}, 32'd0);
    check("mrst_kill", {31'b0, kill_memM}, 32'd0);
    clr_in(); rst = 0; stallF = 1; step();
    check("mrst_drain1", {31'b0, validM}, 32'd0);
    step();
    check("mrst_drain2", {31'b0, validM}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exc_pipe_tracker.md
EXC_PIPE_TRACKER -- requirements
Module: exc_pipe_tracker

Interface
REQ-001 clk  in  1  clock; all state SHALL update on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stallF, stallD, stallE, stallM  in  1 each  hold the corresponding stage register.
REQ-004 flushD, flushE, flushM  in  1 each  hazard flush; the stage register becomes a bubble.
REQ-005 flush_exception  in  1  exception/eret taken at M; flushes D, E and M registers.
REQ-006 pcF  in  32  fetch PC.
REQ-007 riD, syscallD, breakD, eretD, is_branchD  in  1 each  decode results for the instruction in D.
REQ-008 overflowE, trapE  in  1 each  execute-stage results.
REQ-009 mem_readE, mem_writeE  in  1 each; mem_sizeE  in  2  (0 byte, 1 half, 2 word, 3 reserved = word).
REQ-010 aluoutE  in  32  effective address or ALU result.
REQ-011 pcM  out  32  PC of the M-stage instruction, delivered as current_inst_addr to CP0.
REQ-012 in_dsM  out  1  M instruction sits in a branch delay slot.
REQ-013 validM  out  1  M holds a real instruction, not a bubble.
REQ-014 exc_flagsM  out  9  bit0 pcError, bit1 ri, bit2 syscall, bit3 break, bit4 eret, bit5 overflow, bit6 trap, bit7 addrErrLw, bit8 addrErrSw.
REQ-015 badaddrM  out  32  faulting address for CP0 BadVAddr.
REQ-016 kill_memM  out  1  suppress the data-memory access and register writeback for the M instruction.

Function
REQ-017 The block SHALL keep three tracking registers, D, E and M; each holds {valid, pc, in_ds, flags[8:0], badaddr}.
REQ-018 Stage register X SHALL load from its upstream stage when neither stallX nor any flush applies to X.
REQ-019 When stallX=1 and flushX=0, register X SHALL hold.
REQ-020 Flush SHALL override stall: flushX=1 or flush_exception=1 sets X.valid=0 and X.flags=0 on the next edge.
REQ-021 When the upstream stage is stalled and X is not, X SHALL load a bubble (valid=0, flags=0).
REQ-022 F-stage detection is combinational: pcError = (pcF[1:0] != 0).
REQ-023 On F->D load: D.pc = pcF; D.flags[0] = pcError; D.valid = 1.
REQ-024 D.in_ds SHALL be loaded as (D.valid & is_branchD), sampled from the instruction leaving D in the same cycle.
REQ-025 When D is stalled, the delay-slot bit SHALL NOT be recomputed for the held instruction.
REQ-026 On D->E load: flags[4:1] = {eretD, breakD, syscallD, riD}, ORed with the carried flags; all are gated by D.valid.
REQ-027 E-stage misalignment: mis = (size==1 & addr[0]) | (size>=2 & addr[1:0] != 0); byte accesses never fault.
REQ-028 addrErrLw = mem_readE & mis; addrErrSw = mem_writeE & mis & ~mem_readE.
REQ-029 On E->M load: flags[8:5] = {addrErrSw, addrErrLw, trapE, overflowE}.
REQ-030 E-stage flags SHALL be ORed in only if E.flags[4:0] == 0, so an earlier-stage exception suppresses later detection.
REQ-031 badaddr SHALL be loaded as E.pc if E.flags[0]=1, otherwise as aluoutE.
REQ-032 Outputs pcM, in_dsM, validM, exc_flagsM and badaddrM SHALL be driven directly from the M register, with no combinational path from E inputs.
REQ-033 kill_memM = validM & (|exc_flagsM).
REQ-034 Latency: an instruction fetched at edge n with no stalls SHALL appear at M after edge n+3.
REQ-035 If flush_exception and stallM are both 1, the flush SHALL win.
REQ-036 The PC SHALL be carried unmodified; 32-bit values wrap naturally with no special handling.

Reset
REQ-037 On rst, D, E and M SHALL become bubbles with all fields zero.
REQ-038 Reset values: pcM=0, in_dsM=0, validM=0, exc_flagsM=0, badaddrM=0, kill_memM=0.
REQ-039 Reset SHALL dominate stall and flush in the same cycle.
REQ-040 Reset asserted mid-pipeline SHALL discard all in-flight instructions.

Verification
REQ-041 pcF=0xBFC00002, no stalls -> three cycles later validM=1, pcM=0xBFC00002, exc_flagsM=0x001, badaddrM=0xBFC00002, kill_memM=1.
REQ-042 Branch in D (is_branchD=1), next PC 0x80000004 -> that instruction reaches M with in_dsM=1; the following instruction has in_dsM=0.
REQ-043 mem_readE=1, size=2, aluoutE=0x80001002 -> exc_flagsM=0x080, badaddrM=0x80001002; the same access with size=0 -> flags=0.
REQ-044 syscallD=1 and overflowE=1 on the same instruction -> exc_flagsM=0x004 (overflow suppressed).
REQ-045 stallD=1, stallE=0 for 2 cycles -> two bubbles reach M (validM=0); the held D instruction keeps its pc and in_ds.
REQ-046 flush_exception=1 with stallM=1 -> next cycle validM=0 and exc_flagsM=0; rst mid-stream -> all outputs zero.
